// File: rtl/md_unit_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit.
// The pipeline drives the master side; md_unit sits on the slave side.
interface md_unit_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             stall;
   logic             flush;
   logic             md_req;
   logic             busy;
   logic             stall_req;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, stall, flush, md_req,
      input  busy, stall_req, hi, lo
   );

   modport slave (
      input  start, op, a, b, stall, flush, md_req,
      output busy, stall_req, hi, lo
   );
endinterface

// File: rtl/md_unit.sv
// MIPS multiply/divide unit with architectural HI/LO registers.
// Arithmetic ops hold busy for a fixed latency and commit {HI,LO} on the last busy edge.
module md_unit #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic     clk,
   input  logic     reset,
   md_unit_if.slave bus
);
   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               busy_r;
   logic               accept_s;
   logic [2*WIDTH-1:0] res_s;

   // Full 2W product; sign-extending to 2W makes the low 2W bits exact for signed inputs.
   function automatic logic [2*WIDTH-1:0] mul_fn(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             sgn);
      logic [2*WIDTH-1:0] xe;
      logic [2*WIDTH-1:0] ye;
      xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
      ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
      return xe * ye;
   endfunction

   // Returns {remainder, quotient}; dividing magnitudes makes MIN / -1 wrap to MIN with no special case.
   function automatic logic [2*WIDTH-1:0] div_fn(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             sgn);
      logic [WIDTH-1:0] xm;
      logic [WIDTH-1:0] ym;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             neg_x;
      logic             neg_y;
      neg_x = sgn & x[WIDTH-1];
      neg_y = sgn & y[WIDTH-1];
      xm    = neg_x ? ({WIDTH{1'b0}} - x) : x;
      ym    = neg_y ? ({WIDTH{1'b0}} - y) : y;
      if (y == {WIDTH{1'b0}}) begin
         q = {WIDTH{1'b1}};
         r = x;
      end else begin
         q = xm / ym;
         r = xm % ym;
         q = (neg_x ^ neg_y) ? ({WIDTH{1'b0}} - q) : q;
         r = neg_x ? ({WIDTH{1'b0}} - r) : r;
      end
      return {r, q};
   endfunction

   // Accept qualifier: flush and stall both block a new op, including mthi/mtlo
   always_comb begin
      accept_s = 1'b0;
      if (state_r == IDLE) begin
         accept_s = bus.start & ~bus.stall & ~bus.flush;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Result of the latched operation, consumed only on the commit edge
   always_comb begin
      res_s = {(2*WIDTH){1'b0}};
      if (op_r[1]) begin
         res_s = div_fn(a_r, b_r, ~op_r[0]);
      end else begin
         res_s = mul_fn(a_r, b_r, ~op_r[0]);
      end
   end

   // Control FSM, operand latch and HI/LO update
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         busy_r  <= 1'b0;
         op_r    <= 2'b00;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         hi_r    <= {WIDTH{1'b0}};
         lo_r    <= {WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  case (bus.op)
                     3'd0, 3'd1, 3'd2, 3'd3: begin
                        op_r    <= bus.op[1:0];
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        cnt_r   <= bus.op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                     end
                     3'd4:    hi_r <= bus.a;
                     3'd5:    lo_r <= bus.a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (bus.flush) begin
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else if (cnt_r == CNT_W'(1)) begin
                  hi_r    <= res_s[2*WIDTH-1:WIDTH];
                  lo_r    <= res_s[WIDTH-1:0];
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  cnt_r   <= cnt_r - CNT_W'(1);
               end
            end
            default: begin
               cnt_r   <= {CNT_W{1'b0}};
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.stall_req = bus.md_req & busy_r;
   assign bus.hi        = hi_r;
   assign bus.lo        = lo_r;
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with architectural HI/LO registers for the MIPS pipeline, sitting in the execute stage beside the ALU. It computes mult/multu/div/divu over configurable latencies, executes mthi/mtlo, and drives a stall request for HI/LO-dependent instructions in decode. It adds operand latching, result commit, flush-abort and divide-by-zero handling on top of plain busy tracking.

## Interface
- WIDTH, 32: operand and HI/LO width (≥ 2).
- MULT_LAT, 5: busy cycles for mult/multu (≥ 1).
- DIV_LAT, 10: busy cycles for div/divu (≥ 1).
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  execute-stage instruction is an md op this cycle.
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no-op).
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- stall  in  1  pipeline stalled; start is ignored while high.
- flush  in  1  abort in-flight op; HI/LO not updated.
- md_req  in  1  decode-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  an arithmetic op is in flight.
- stall_req  out  1  md_req & busy.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.

## Operation
- States: IDLE, RUN. Reset: IDLE, counter 0, busy 0, stall_req 0, hi 0, lo 0.
- Accept condition: state IDLE & start & !stall & !flush & !reset.
- Accepted op 0–3: latch a, b, op; load counter with MULT_LAT or DIV_LAT; go RUN. Result may be computed at accept or over the run; only the commit edge is observable.
- Accepted op 4/5: hi<=a or lo<=a at that edge; stay IDLE; busy stays 0.
- Op 6/7 accepted: no state change.
- RUN: counter decrements each cycle; on the edge where counter==1, commit HI/LO and go IDLE.
- start while RUN: ignored (decode is held off via stall_req; bench still checks no effect).
- flush in RUN: go IDLE at next edge, counter 0, HI/LO unchanged. flush in IDLE suppresses same-cycle accept (including mthi/mtlo).
- reset mid-operation: IDLE, HI/LO cleared, no commit.
- Arithmetic: mult signed 2W product {hi,lo}; multu unsigned. div signed: lo=quotient truncated toward zero, hi=remainder with sign of dividend. divu unsigned.
- Divide by zero (b==0, div or divu): hi=a, lo=all ones; same latency.
- Signed overflow (div, a=most-negative, b=-1): lo=most-negative, hi=0.
- Operands used are the latched values; a/b changes during RUN have no effect.

## Timing
- Accept at edge E0 → busy high for exactly LAT cycles after E0; HI/LO show result in the first cycle busy is low again (edge E0+LAT).
- mthi/mtlo: hi/lo visible one cycle after accept edge.
- busy and stall_req are registered-state functions (no combinational path from start); stall_req combinational in md_req only.
- Back-to-back: new op accepted in the cycle busy first reads 0.
- Counter width clog2(max(MULT_LAT,DIV_LAT)+1); LAT=1 gives one busy cycle.

## Test plan
- mult a=-3 (0xFFFFFFFD), b=5 → busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1; multu same operands → hi=0x00000004, lo=0xFFFFFFF1.
- divu a=100, b=7 → busy 10 cycles, lo=14, hi=2; div a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- div a=0x1234, b=0 → after 10 cycles hi=0x1234, lo=0xFFFFFFFF.
- mthi a=0xAAAA then mult started with stall=1 → no busy, hi=0xAAAA; start mult, flush on 3rd busy cycle → busy drops next cycle, hi=0xAAAA, lo unchanged.
- start div while mult in RUN (different a/b on bus) → ignored, mult result committed at its own cycle; md_req=1 during busy → stall_req=1, 0 after.
- reset asserted mid-div → next cycle busy=0, hi=lo=0, no later commit; MULT_LAT=1 build → busy exactly one cycle.
